path_backtracker: RTL and testbench
===================================

# path_backtracker

Move-history LIFO for the maze-walker, the reverse of the next-location datapath. Records every accepted 2-bit step direction during forward exploration. On a dead end it pops the last step and produces the previous location by applying the inverse move. On completion it replays the stored path from a start location as a stream of locations under a valid/ready handshake. It sits between the controller, which pushes, pops and starts replay, and the path-output consumer.

## Interface
- `AW`, 4: address width; stack depth = 2**AW entries.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  record `pushDir` as a new top entry.
- `pushDir`  in  2  direction of the step just taken.
- `pop`  in  1  remove top entry and compute the previous location.
- `currLoc`  in  8  current location, {X[7:4], Y[3:0]}.
- `prevLoc`  out  8  location before the popped step; registered.
- `popDir`  out  2  direction of the popped entry; registered.
- `popValid`  out  1  one-cycle pulse: `prevLoc`/`popDir` updated.
- `count`  out  AW+1  number of stored entries.
- `empty`  out  1  `count`==0.
- `full`  out  1  `count`==2**AW.
- `ovf`  out  1  sticky flag: a push was attempted while full.
- `startReplay`  in  1  begin replay from `startLoc`.
- `startLoc`  in  8  replay origin.
- `outValid`  out  1  `outLoc`/`outDir` valid.
- `outLoc`  out  8  location after applying `outDir`.
- `outDir`  out  2  stored step being replayed.
- `rdy`  in  1  consumer accepts the current output.
- `replayDone`  out  1  one-cycle pulse at the end of replay.

## Operation
- Direction encoding is shared with the walker:
  - Axis = X when `dir[1]^dir[0]`, else Y.
  - Delta = +1 when `dir[0]`, else -1.
  - 00 gives Y-1; 01 gives X+1; 10 gives X-1; 11 gives Y+1.
  - Inverse of `d` is `~d`.
- Arithmetic is 4-bit per axis, modulo 16. The untouched axis passes through unchanged.
- States: IDLE, REPLAY, DONE.
- IDLE, push only, not full: `mem[sp]` <= `pushDir`; sp++.
- IDLE, push only, full: entry dropped; sp unchanged; `ovf` <= 1.
- IDLE, pop, not empty:
  - sp--.
  - `popDir` <= `mem[sp-1]`.
  - `prevLoc` <= `currLoc` moved by `~mem[sp-1]`.
  - `popValid` <= 1 for one cycle.
- IDLE, pop, empty: ignored; `popValid` stays 0; outputs hold.
- IDLE, push and pop in the same cycle: pop wins and push is dropped. `ovf` is not set.
- IDLE, `startReplay` asserted: sampled only in IDLE; higher priority than push/pop in the same cycle.
  - Not empty: loc <= `startLoc`; idx <= 0; go to REPLAY.
  - Empty: go to DONE.
- REPLAY:
  - `outValid`=1, `outDir`=`mem[idx]`, `outLoc`=loc moved by `mem[idx]` (combinational from loc/idx).
  - On `outValid`&&`rdy`: loc <= `outLoc`; idx++.
  - If idx was sp-1 on that handshake: go to DONE.
  - While `rdy`=0, `outLoc`/`outDir` hold stable.
- DONE: `replayDone`=1 for exactly one cycle, then IDLE. The stack contents and sp are preserved, so replay can be repeated.
- In REPLAY and DONE, push, pop and `startReplay` are ignored; `ovf` is not affected.

## Timing
- Reset values:
  - sp=0, state IDLE, `ovf`=0.
  - `prevLoc`=8'h00, `popDir`=2'b00.
  - `popValid`=0, `outValid`=0, `replayDone`=0.
  - `count`=0, `empty`=1, `full`=0.
  - `outLoc`/`outDir` are don't-care while `outValid`=0.
- Memory contents are not reset.
- Push: `count` updates the cycle after the request edge.
- Pop: `prevLoc`/`popDir`/`popValid` appear one cycle after the pop edge; `count` updates on the same edge.
- `startReplay` at edge N: `outValid`=1 from cycle N+1.
- Replay throughput: one location per cycle while `rdy`=1.
- Last handshake at edge M: `outValid`=0 and `replayDone`=1 in cycle M+1; IDLE in cycle M+2.
- Empty replay: `replayDone`=1 in cycle N+1 with `outValid` never asserted.
- `rst` during REPLAY: next cycle is the reset state; stack emptied; no `replayDone` pulse.

## Test plan
- Reset, then push 01, 01, 11; `startReplay` with `startLoc`=8'h00 and `rdy`=1:
  - `outLoc` = 8'h10, 8'h20, 8'h21 on consecutive cycles.
  - `outDir` = 01, 01, 11.
  - `replayDone` pulses once; `count` stays 3.
- Same stack with `currLoc`=8'h21, pop: next cycle `prevLoc`=8'h20, `popDir`=11, `popValid`=1, `count`=2.
- Wrap: push 01, pop with `currLoc`=8'h05 -> `prevLoc`=8'hF5. Push 11, pop with `currLoc`=8'h30 -> `prevLoc`=8'h3F.
- Fill 16 entries, then:
  - A 17th push -> `count`=16, `full`=1, `ovf`=1.
  - Pop on empty after draining -> `popValid`=0.
  - Push+pop in the same cycle with `count`=2 -> `count`=1, popped entry is the old top.
- Replay of 3 entries with `rdy` toggling 1,0,0,1,1: each `outLoc` held stable while `rdy`=0; `replayDone` follows the third handshake.
- Extra cases:
  - `startReplay` while empty -> `replayDone` pulse, no `outValid`.
  - `rst` asserted mid-REPLAY -> `outValid`=0, `count`=0, no `replayDone`.

Source files
------------

// File: rtl/path_backtracker.sv
// Move-history LIFO for the maze walker: records step directions, undoes the
// top step on a dead end and replays the stored path under valid/ready.
module path_backtracker #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [1:0]    pushDir,
    input  logic          pop,
    input  logic [7:0]    currLoc,
    output logic [7:0]    prevLoc,
    output logic [1:0]    popDir,
    output logic          popValid,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    input  logic          startReplay,
    input  logic [7:0]    startLoc,
    output logic          outValid,
    output logic [7:0]    outLoc,
    output logic [1:0]    outDir,
    input  logic          rdy,
    output logic          replayDone
);

    typedef enum logic [1:0] {
        IDLE,
        REPLAY,
        DONE
    } stateT;

    stateT          state;
    logic [AW:0]    sp;
    logic [AW:0]    spLast;
    logic [AW-1:0]  idx;
    logic [7:0]     loc;
    logic [1:0]     topDir;
    logic           memWe;
    logic [1:0]     mem [2**AW];

    // dir[1]^dir[0] selects the X axis, dir[0] selects +1; 4-bit wrap per axis.
    function automatic logic [7:0] moveLoc(input logic [7:0] l, input logic [1:0] d);
        logic [3:0] x;
        logic [3:0] y;
        x = l[7:4];
        y = l[3:0];
        if (d[1] ^ d[0]) x = d[0] ? x + 4'd1 : x - 4'd1;
        else             y = d[0] ? y + 4'd1 : y - 4'd1;
        return {x, y};
    endfunction

    assign count      = sp;
    assign empty      = (sp == '0);
    assign full       = sp[AW];
    assign spLast     = sp - 1'b1;
    assign topDir     = mem[spLast[AW-1:0]];
    assign outValid   = (state == REPLAY);
    assign replayDone = (state == DONE);
    assign outDir     = mem[idx];
    assign outLoc     = moveLoc(loc, mem[idx]);

    // Push only lands when neither startReplay nor pop outranks it.
    assign memWe = !rst && (state == IDLE) && push && !pop && !startReplay && !full;

    always_ff @(posedge clk) begin
        if (memWe) mem[sp[AW-1:0]] <= pushDir;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sp       <= '0;
            ovf      <= 1'b0;
            prevLoc  <= '0;
            popDir   <= '0;
            popValid <= 1'b0;
            loc      <= '0;
            idx      <= '0;
        end else begin
            popValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (startReplay) begin
                        if (empty) begin
                            state <= DONE;
                        end else begin
                            loc   <= startLoc;
                            idx   <= '0;
                            state <= REPLAY;
                        end
                    end else if (pop) begin
                        if (!empty) begin
                            sp       <= spLast;
                            popDir   <= topDir;
                            prevLoc  <= moveLoc(currLoc, ~topDir);
                            popValid <= 1'b1;
                        end
                    end else if (push) begin
                        if (full) ovf <= 1'b1;
                        else      sp  <= sp + 1'b1;
                    end
                end
                REPLAY: begin
                    if (rdy) begin
                        loc <= outLoc;
                        idx <= idx + 1'b1;
                        if ({1'b0, idx} == spLast) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_path_backtracker.sv
// Directed plus randomized bench for path_backtracker against a queue-based
// model of the move history and per-direction (dx, dy) step table.
module tb_path_backtracker;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [1:0]    pushDir = '0;
    logic          pop = 1'b0;
    logic [7:0]    currLoc = '0;
    logic [7:0]    prevLoc;
    logic [1:0]    popDir;
    logic          popValid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          startReplay = 1'b0;
    logic [7:0]    startLoc = '0;
    logic          outValid;
    logic [7:0]    outLoc;
    logic [1:0]    outDir;
    logic          rdy = 1'b0;
    logic          replayDone;

    path_backtracker #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .push(push), .pushDir(pushDir), .pop(pop),
        .currLoc(currLoc), .prevLoc(prevLoc), .popDir(popDir), .popValid(popValid),
        .count(count), .empty(empty), .full(full), .ovf(ovf),
        .startReplay(startReplay), .startLoc(startLoc), .outValid(outValid),
        .outLoc(outLoc), .outDir(outDir), .rdy(rdy), .replayDone(replayDone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [1:0] stk[$];
    logic       mOvf = 1'b0;
    logic [7:0] mPrev = 8'h00;
    logic [1:0] mPopDir = 2'b00;

    function automatic logic [7:0] walk(input logic [7:0] l, input logic [1:0] d, input bit undo);
        int dx, dy, x, y;
        dx = 0; dy = 0;
        case (d)
            2'd0: dy = -1;
            2'd1: dx = 1;
            2'd2: dx = -1;
            default: dy = 1;
        endcase
        if (undo) begin dx = -dx; dy = -dy; end
        x = (int'(l[7:4]) + dx + 16) % 16;
        y = (int'(l[3:0]) + dy + 16) % 16;
        return {x[3:0], y[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chkStatus(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(stk.size()));
        chk({tag, ".empty"}, 32'(empty), 32'(stk.size() == 0));
        chk({tag, ".full"},  32'(full),  32'(stk.size() == DEPTH));
        chk({tag, ".ovf"},   32'(ovf),   32'(mOvf));
    endtask

    task automatic doPush(input logic [1:0] d);
        push = 1'b1; pushDir = d;
        step();
        push = 1'b0;
        if (stk.size() < DEPTH) stk.push_back(d);
        else mOvf = 1'b1;
        chkStatus("push");
        chk("push.popValid", 32'(popValid), 32'd0);
    endtask

    task automatic doPop(input logic [7:0] cl, input bit withPush, input logic [1:0] pd);
        bit had;
        pop = 1'b1; currLoc = cl; push = withPush; pushDir = pd;
        step();
        pop = 1'b0; push = 1'b0;
        had = (stk.size() != 0);
        if (had) begin
            mPopDir = stk.pop_back();
            mPrev   = walk(cl, mPopDir, 1'b1);
        end
        chk("pop.popValid", 32'(popValid), 32'(had));
        chk("pop.prevLoc",  32'(prevLoc),  32'(mPrev));
        chk("pop.popDir",   32'(popDir),   32'(mPopDir));
        chkStatus("pop");
        step();
        chk("pop.pulseEnd", 32'(popValid), 32'd0);
    endtask

    // mode 0: rdy always 1; mode 1: rdy 1,0,0,1,1 repeating; mode 2: random
    task automatic doReplay(input logic [7:0] sl, input int mode);
        logic [7:0] l;
        int k, cyc, n;
        bit pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        n = stk.size();
        startReplay = 1'b1; startLoc = sl;
        step();
        startReplay = 1'b0;
        l = sl; k = 0; cyc = 0;
        while (k < n && cyc < 2000) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = pat[cyc % 5];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            chk("replay.outValid", 32'(outValid), 32'd1);
            chk("replay.outDir",   32'(outDir),   32'(stk[k]));
            chk("replay.outLoc",   32'(outLoc),   32'(walk(l, stk[k], 1'b0)));
            chk("replay.doneLow",  32'(replayDone), 32'd0);
            if (rdy) begin
                l = walk(l, stk[k], 1'b0);
                k++;
            end
            step();
            cyc++;
        end
        rdy = 1'b0;
        chk("replay.bound", 32'(k), 32'(n));
        chk("replay.endValid", 32'(outValid), 32'd0);
        chk("replay.done",     32'(replayDone), 32'd1);
        step();
        chk("replay.donePulse", 32'(replayDone), 32'd0);
        chkStatus("replay");
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chkStatus("reset");
        chk("reset.prevLoc",    32'(prevLoc),    32'h00);
        chk("reset.popDir",     32'(popDir),     32'h0);
        chk("reset.popValid",   32'(popValid),   32'd0);
        chk("reset.outValid",   32'(outValid),   32'd0);
        chk("reset.replayDone", 32'(replayDone), 32'd0);

        // basic path and replay from origin
        doPush(2'b01); doPush(2'b01); doPush(2'b11);
        doReplay(8'h00, 0);
        doPop(8'h21, 1'b0, 2'b00);
        chk("plan.prev21", 32'(prevLoc), 32'h20);

        // wrap-around on both axes
        doPush(2'b01);
        doPop(8'h05, 1'b0, 2'b00);
        chk("plan.wrapX", 32'(prevLoc), 32'hF5);
        doPush(2'b11);
        doPop(8'h30, 1'b0, 2'b00);
        chk("plan.wrapY", 32'(prevLoc), 32'h3F);

        // fill, overflow, random full replay
        while (stk.size() < DEPTH) doPush(2'($urandom_range(0, 3)));
        doPush(2'b10);
        chk("plan.ovf", 32'(ovf), 32'd1);
        doReplay(8'($urandom), 2);

        // drain with random locations, then pop on empty
        while (stk.size() > 0) doPop(8'($urandom), 1'b0, 2'b00);
        doPop(8'h77, 1'b0, 2'b00);

        // push+pop together: pop wins
        doPush(2'b10); doPush(2'b00);
        doPop(8'h44, 1'b1, 2'b11);
        chk("plan.pushPopDir", 32'(popDir), 32'h0);
        doPop(8'h44, 1'b0, 2'b00);

        // stall pattern on rdy
        doPush(2'b01); doPush(2'b11); doPush(2'b10);
        doReplay(8'hE2, 1);
        for (int i = 0; i < 6; i++) doReplay(8'($urandom), 2);

        // empty replay
        while (stk.size() > 0) doPop(8'($urandom), 1'b0, 2'b00);
        doReplay(8'h12, 0);

        // reset in the middle of a replay
        doPush(2'b00); doPush(2'b01); doPush(2'b11);
        startReplay = 1'b1; startLoc = 8'h88;
        step();
        startReplay = 1'b0;
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        chk("rstMid.outValidBefore", 32'(outValid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        stk.delete();
        mOvf = 1'b0;
        chk("rstMid.outValid", 32'(outValid),   32'd0);
        chk("rstMid.done",     32'(replayDone), 32'd0);
        chkStatus("rstMid");
        step();
        chk("rstMid.doneAfter", 32'(replayDone), 32'd0);
        chk("rstMid.validAfter", 32'(outValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
